// File: rtl/bias_load_ctrl_if.sv
// Bias loader bus interface.
// Groups the load request, read request/return channel, bias register write
// port and status flags of bias_load_ctrl.
//   start_i, base_addr_i, num_pkg_i   : load request (host -> loader)
//   rd_req_o, rd_addr_o, rd_ack_i     : read request channel
//   rd_valid_i, rd_data_i             : in-order read data return
//   bias_en_o, bias_addr_o, bias_data_o : bias register array write port
//   busy_o, done_o, err_o             : status
// Modports: slave = loader side, master = host/memory side.
interface bias_load_ctrl_if #(
  parameter int DW = 512,
  parameter int AW = 32
) ();
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [4:0]    num_pkg_i;
  logic          rd_req_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_ack_i;
  logic          rd_valid_i;
  logic [DW-1:0] rd_data_i;
  logic          bias_en_o;
  logic [4:0]    bias_addr_o;
  logic [DW-1:0] bias_data_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  modport slave (
    input  start_i, base_addr_i, num_pkg_i, rd_ack_i, rd_valid_i, rd_data_i,
    output rd_req_o, rd_addr_o, bias_en_o, bias_addr_o, bias_data_o,
           busy_o, done_o, err_o
  );

  modport master (
    output start_i, base_addr_i, num_pkg_i, rd_ack_i, rd_valid_i, rd_data_i,
    input  rd_req_o, rd_addr_o, bias_en_o, bias_addr_o, bias_data_o,
           busy_o, done_o, err_o
  );
endinterface

// File: rtl/bias_load_ctrl.sv
// Bias load controller.
// Fetches N packages (N = num_pkg_i, 0 meaning 32) of DW bits each from
// consecutive addresses starting at base_addr_i and writes package k into
// bias register k. Requests and data returns are counted independently, so
// data may come back while requests are still outstanding.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   bus    - bias_load_ctrl_if.slave (request, read channel, write port,
//            busy/done/err status)
// Optional feature: define BIAS_LOAD_TIMEOUT_EN to add a LOAD watchdog that
// aborts the load with a one-cycle err_o pulse after TMO quiet cycles.
// Without it err_o is constant 0.
module bias_load_ctrl #(
  parameter int DW  = 512,
  parameter int FW  = 32,
  parameter int RL  = 512,
  parameter int AW  = 32,
  parameter int TMO = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bias_load_ctrl_if.slave   bus
);

  localparam logic [AW-1:0] PKG_BYTES = AW'(DW / 8);
  // Packages that fit in the bias array; caps N for non-default geometries.
  localparam int            MAX_PKG   = RL / (DW / FW);
  localparam logic [5:0]    PKG_CAP   = (MAX_PKG >= 32) ? 6'd32 : 6'(MAX_PKG);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] base_q;
  logic [5:0]    npkg_q;
  logic [5:0]    req_cnt;
  logic [5:0]    dat_cnt;
  logic [5:0]    npkg_in;
  logic          start_acc;
  logic          req_pend;
  logic          ack_acc;
  logic          wr_acc;
  logic          timeout;

  logic          wr_en_p1;
  logic [4:0]    wr_addr_p1;
  logic [DW-1:0] wr_data_p1;

  always_comb begin
    npkg_in = (bus.num_pkg_i == 5'd0) ? 6'd32 : {1'b0, bus.num_pkg_i};
    if (npkg_in > PKG_CAP) npkg_in = PKG_CAP;
  end

  assign start_acc = (state == IDLE) && bus.start_i;
  assign req_pend  = (state == LOAD) && (req_cnt < npkg_q);
  assign ack_acc   = req_pend && bus.rd_ack_i;
  assign wr_acc    = (state == LOAD) && bus.rd_valid_i && (dat_cnt < npkg_q);

`ifdef BIAS_LOAD_TIMEOUT_EN
  localparam int WDW = $clog2(TMO + 1);

  logic [WDW-1:0] wdog;
  logic           err_q;

  // The cycle with activity (or the start cycle) counts as quiet cycle 0,
  // so the abort lands exactly TMO cycles after the last activity.
  assign timeout = (state == LOAD) && !bus.rd_ack_i && !bus.rd_valid_i &&
                   (dat_cnt != npkg_q) && (wdog == WDW'(TMO - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (start_acc || bus.rd_ack_i || bus.rd_valid_i) wdog <= WDW'(1);
      else if (state == LOAD)                          wdog <= wdog + WDW'(1);
    end
  end

  assign bus.err_o = err_q;
`else
  assign timeout   = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = LOAD;
      LOAD: begin
        if (dat_cnt == npkg_q) state_nxt = FIN;
        else if (timeout)      state_nxt = IDLE;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy_o    = (state == LOAD);
    bus.done_o    = (state == FIN);
    bus.rd_req_o  = req_pend;
    bus.rd_addr_o = '0;
    if (req_pend) bus.rd_addr_o = base_q + AW'(req_cnt) * PKG_BYTES;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q  <= '0;
      npkg_q  <= '0;
      req_cnt <= '0;
      dat_cnt <= '0;
    end else if (start_acc) begin
      base_q  <= bus.base_addr_i;
      npkg_q  <= npkg_in;
      req_cnt <= '0;
      dat_cnt <= '0;
    end else begin
      if (ack_acc) req_cnt <= req_cnt + 6'd1;
      if (wr_acc)  dat_cnt <= dat_cnt + 6'd1;
    end
  end

  // Stage p1: registered bias write; address/data hold between writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= wr_acc;
      if (wr_acc) begin
        wr_addr_p1 <= dat_cnt[4:0];
        wr_data_p1 <= bus.rd_data_i;
      end
    end
  end

  assign bus.bias_en_o   = wr_en_p1;
  assign bus.bias_addr_o = wr_addr_p1;
  assign bus.bias_data_o = wr_data_p1;

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Testbench for bias_load_ctrl: directed loads plus randomized acknowledge
// and return latency, checked against a transaction-level model of the load
// (expected address list, expected write list, watchdog deadline).
module tb_bias_load_ctrl;
  localparam int DW  = 512;
  localparam int AW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bias_load_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  bias_load_ctrl #(.DW(DW), .FW(32), .RL(512), .AW(AW), .TMO(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.num_pkg_i   = '0;
    bus.rd_ack_i    = 1'b0;
    bus.rd_valid_i  = 1'b0;
    bus.rd_data_i   = '0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_quiet(input string tag);
    check_val({tag, "_rd_req"},    bus.rd_req_o,    0);
    check_val({tag, "_rd_addr"},   bus.rd_addr_o,   0);
    check_val({tag, "_bias_en"},   bus.bias_en_o,   0);
    check_val({tag, "_bias_addr"}, bus.bias_addr_o, 0);
    check_val({tag, "_bias_data"}, bus.bias_data_o, 0);
    check_val({tag, "_busy"},      bus.busy_o,      0);
    check_val({tag, "_done"},      bus.done_o,      0);
    check_val({tag, "_err"},       bus.err_o,       0);
  endtask

  // One load transaction. Package k must be requested at base + 64*k, and
  // the k-th data word returned must land in bias register k.
  //   ack_pct        : chance of acknowledging a pending request per cycle
  //   stall_idx      : request index held unacknowledged for 5 cycles (-1 none)
  //   lat            : ack-to-data latency (0 = random 1..4, kept in order)
  //   poke_start     : pulse start_i with other arguments mid-load
  //   extra_valids   : stray data beats sent after done_o
  //   rst_after      : assert reset once this many writes are seen (-1 none)
  //   withhold_after : stop returning data after this many beats (-1 none)
  task automatic run_load(input logic [AW-1:0] base, input logic [4:0] num,
                          input int ack_pct, input int stall_idx, input int lat,
                          input bit poke_start, input int extra_valids,
                          input int rst_after, input int withhold_after);
    logic [DW-1:0] exp_data[$];
    int            q_due[$];
    logic [DW-1:0] d;
    logic [AW-1:0] prev_addr, exp_addr;
    int n, req_idx, wr_idx, last_wr, last_act, last_due, stall_left;
    int start_cyc, extra_left, post_cnt, due;
    bit prev_req, prev_ack, done_seen, timed_out, exp_err, stop;

    n          = (num == 5'd0) ? 32 : int'(num);
    req_idx    = 0;
    wr_idx     = 0;
    last_wr    = -10;
    last_due   = -10;
    stall_left = 5;
    extra_left = extra_valids;
    post_cnt   = 0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = '0;
    done_seen  = 1'b0;
    timed_out  = 1'b0;
    stop       = 1'b0;

    idle_inputs();
    bus.start_i     = 1'b1;
    bus.base_addr_i = base;
    bus.num_pkg_i   = num;
    tick();
    idle_inputs();
    start_cyc = cyc;
    last_act  = cyc - 1;

    for (int k = 0; k < 400 && !stop; k++) begin
      bus.rd_ack_i   = 1'b0;
      bus.rd_valid_i = 1'b0;
      bus.start_i    = 1'b0;

      if (bus.bias_en_o) begin
        if (wr_idx < exp_data.size()) begin
          check_val("bias_addr", bus.bias_addr_o, wr_idx);
          check_val("bias_data", bus.bias_data_o, exp_data[wr_idx]);
        end else begin
          check_val("unexpected_write", bus.bias_en_o, 0);
        end
        wr_idx++;
        last_wr = cyc;
      end

      if (bus.done_o) begin
        check_val("done_after_last_write", cyc, last_wr + 1);
        check_val("write_count", wr_idx, n);
        done_seen = 1'b1;
      end

      exp_err = 1'b0;
`ifdef BIAS_LOAD_TIMEOUT_EN
      if (withhold_after >= 0 && !timed_out && cyc == last_act + TMO) begin
        exp_err   = 1'b1;
        timed_out = 1'b1;
      end
`endif
      check_val("err", bus.err_o, exp_err);
      check_val("busy", bus.busy_o, !done_seen && !timed_out);
      check_val("rd_req", bus.rd_req_o, !done_seen && !timed_out && req_idx < n);

      if (prev_req && !prev_ack) begin
        check_val("rd_req_hold", bus.rd_req_o, 1);
        check_val("rd_addr_hold", bus.rd_addr_o, prev_addr);
      end
      prev_req  = bus.rd_req_o;
      prev_addr = bus.rd_addr_o;
      prev_ack  = 1'b0;

      if (bus.rd_req_o) begin
        if (req_idx == stall_idx && stall_left > 0) begin
          stall_left--;
        end else if (int'($urandom_range(99)) < ack_pct) begin
          bus.rd_ack_i = 1'b1;
          prev_ack     = 1'b1;
          exp_addr     = base + AW'(req_idx * 64);
          check_val("rd_addr", bus.rd_addr_o, exp_addr);
          req_idx++;
          last_act = cyc;
          due = cyc + ((lat > 0) ? lat : int'($urandom_range(4, 1)));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          q_due.push_back(due);
        end
      end

      if (q_due.size() > 0 && q_due[0] <= cyc &&
          (withhold_after < 0 || exp_data.size() < withhold_after)) begin
        void'(q_due.pop_front());
        d              = rnd_data();
        bus.rd_valid_i = 1'b1;
        bus.rd_data_i  = d;
        exp_data.push_back(d);
        last_act = cyc;
      end else if (done_seen && extra_left > 0) begin
        bus.rd_valid_i = 1'b1;
        bus.rd_data_i  = rnd_data();
        extra_left--;
      end

      if (poke_start && cyc == start_cyc + 3) begin
        bus.start_i     = 1'b1;
        bus.base_addr_i = base ^ 32'h0000_5000;
        bus.num_pkg_i   = 5'd3;
      end

      if (rst_after >= 0 && bus.bias_en_o && wr_idx == rst_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check_quiet("after_reset");
        for (int j = 0; j < 4; j++) begin
          tick();
          check_val("no_done_after_reset", bus.done_o, 0);
          check_val("idle_after_reset", bus.busy_o, 0);
        end
        stop = 1'b1;
      end else begin
        tick();
        if (done_seen || timed_out) post_cnt++;
        if (post_cnt > extra_valids + 3) stop = 1'b1;
        if (withhold_after >= 0 && k >= TMO + 20) stop = 1'b1;
      end
    end

    idle_inputs();
    if (rst_after < 0 && withhold_after < 0)
      check_val("load_completed", done_seen, 1);
    if (withhold_after >= 0)
      check_val("no_done_when_starved", done_seen, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.start_i = 1'b1;      // coincident with reset: must be ignored
    tick();
    bus.start_i = 1'b0;
    tick();
    check_quiet("in_reset");
    rst = 1'b0;
    tick();
    check_quiet("after_release");

    // Basic load, ack always, data 2 cycles after each ack
    run_load(32'h0000_1000, 5'd4, 100, -1, 2, 1'b0, 0, -1, -1);
    // num_pkg_i = 0 -> 32 packages
    run_load(32'h0000_2000, 5'd0, 100, -1, 2, 1'b0, 0, -1, -1);
    // Second request held off for 5 cycles
    run_load(32'h0000_3000, 5'd6, 100, 1, 2, 1'b0, 0, -1, -1);
    // start_i while busy plus stray data after completion
    run_load(32'h0000_4000, 5'd5, 100, -1, 2, 1'b1, 2, -1, -1);
    // Reset after 3 of 8 writes, then a clean reload
    run_load(32'h0000_5000, 5'd8, 100, -1, 2, 1'b0, 0, 3, -1);
    run_load(32'h0000_6000, 5'd8, 100, -1, 2, 1'b0, 0, -1, -1);
    // Data withheld after the second write
    run_load(32'h0000_7000, 5'd4, 100, -1, 2, 1'b0, 0, -1, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_quiet("after_starved_load");

    // Address wrap at the top of the address space
    run_load(32'hFFFF_FF80, 5'd4, 70, -1, 0, 1'b0, 0, -1, -1);
    // Randomized loads
    for (int i = 0; i < 6; i++)
      run_load($urandom & 32'hFFFF_FFC0, 5'($urandom_range(31)),
               int'($urandom_range(100, 40)), -1, 0, 1'b0, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
